// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate boundary modes,
// a terminal-count pulse and a sticky overflow flag.
module updown_mod_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             boundary;
  logic             ovf_nxt;

  // A full-range modulus can never see an out-of-range load value.
  generate
    if (MAX_VAL == 2**WIDTH - 1) begin : g_no_clamp
      assign load_clamped = load_val;
    end else begin : g_clamp
      assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;
    end
  endgenerate

  assign at_max = (count == MAX_C);
  assign at_min = (count == '0);

  always_comb begin
    count_nxt = count;
    boundary  = 1'b0;
    if (load) begin
      count_nxt = load_clamped;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
          boundary  = 1'b1;
          count_nxt = sat_mode ? count : '0;
        end else begin
          count_nxt = count + ONE;
        end
      end else begin
        if (at_min) begin
          boundary  = 1'b1;
          count_nxt = sat_mode ? count : MAX_C;
        end else begin
          count_nxt = count - ONE;
        end
      end
    end
  end

  // Set beats clear when a boundary event and clr_ovf coincide.
  assign ovf_nxt = boundary | (ovf & ~clr_ovf);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= RST_C;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      tc    <= boundary;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed, table-driven bench for updown_mod_counter (WIDTH=4, MAX_VAL=9).
module tb_updown_mod_counter;

  localparam int W = 4;
  localparam int MAXV = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, up_dn, sat_mode, load, clr_ovf;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, ovf, at_max, at_min;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic         en, up_dn, sat_mode, load, clr_ovf;
    logic [W-1:0] load_val;
    int           exp_count;
    logic         exp_tc, exp_ovf;
  } vec_t;

  vec_t vecs[$];

  updown_mod_counter #(.WIDTH(W), .MAX_VAL(MAXV), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count), .tc(tc), .ovf(ovf), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int ec, input logic et, input logic eo);
    chk({name, ".count"}, int'(count), ec);
    chk({name, ".tc"}, int'(tc), int'(et));
    chk({name, ".ovf"}, int'(ovf), int'(eo));
    chk({name, ".at_max"}, int'(at_max), (ec == MAXV) ? 1 : 0);
    chk({name, ".at_min"}, int'(at_min), (ec == 0) ? 1 : 0);
  endtask

  function automatic void add(input string name, input logic e, input logic u, input logic s,
                              input logic l, input int lv, input logic c,
                              input int ec, input logic et, input logic eo);
    vec_t v;
    v.name = name; v.en = e; v.up_dn = u; v.sat_mode = s; v.load = l;
    v.load_val = W'(lv); v.clr_ovf = c;
    v.exp_count = ec; v.exp_tc = et; v.exp_ovf = eo;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic e, input logic u, input logic s, input logic l,
                       input int lv, input logic c);
    en = e; up_dn = u; sat_mode = s; load = l; load_val = W'(lv); clr_ovf = c;
  endtask

  task automatic step(input logic e, input logic u, input logic s, input logic l,
                      input int lv, input logic c);
    drive(e, u, s, l, lv, c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // name, en, up, sat, load, lval, clr, count, tc, ovf
    for (int i = 1; i <= 9; i++) add("wrap_up", 1, 1, 0, 0, 0, 0, i, 0, 0);
    add("wrap_up_tc",     1, 1, 0, 0, 0,  0, 0, 1, 1);
    add("wrap_up_after",  1, 1, 0, 0, 0,  0, 1, 0, 1);
    add("clr_ovf",        0, 1, 0, 0, 0,  1, 1, 0, 0);
    add("load2",          0, 0, 1, 1, 2,  0, 2, 0, 0);
    add("sat_dn1",        1, 0, 1, 0, 0,  0, 1, 0, 0);
    add("sat_dn0",        1, 0, 1, 0, 0,  0, 0, 0, 0);
    add("sat_dn_hold1",   1, 0, 1, 0, 0,  0, 0, 1, 1);
    add("sat_dn_hold2",   1, 0, 1, 0, 0,  0, 0, 1, 1);
    add("sat_dn_en0",     0, 0, 1, 0, 0,  0, 0, 0, 1);
    add("load_clamp",     1, 1, 0, 1, 12, 0, 9, 0, 1);
    add("load3",          1, 1, 0, 1, 3,  0, 3, 0, 1);
    add("down_step",      1, 0, 0, 0, 0,  0, 2, 0, 1);
    add("clr_ovf2",       0, 0, 0, 0, 0,  1, 2, 0, 0);
    add("load9",          0, 1, 0, 1, 9,  0, 9, 0, 0);
    add("set_vs_clr",     1, 1, 0, 0, 0,  1, 0, 1, 1);
    add("clr_after",      0, 1, 0, 0, 0,  1, 0, 0, 0);
    add("wrap_dn",        1, 0, 0, 0, 0,  0, 9, 1, 1);
    add("wrap_dn_next",   1, 0, 0, 0, 0,  0, 8, 0, 1);
    add("load_at_bound",  1, 1, 1, 1, 9,  0, 9, 0, 1);
    add("sat_up",         1, 1, 1, 0, 0,  1, 9, 1, 1);
    add("load7",          0, 0, 0, 1, 7,  0, 7, 0, 1);
    for (int i = 0; i < 5; i++) add("hold", 0, i[0], ~i[0], 0, 0, 0, 7, 0, 1);
    add("load9b",         0, 1, 0, 1, 9,  0, 9, 0, 1);
    add("wrap_pre_rst",   1, 1, 0, 0, 0,  0, 0, 1, 1);
    add("load5",          1, 1, 0, 1, 5,  0, 5, 0, 1);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk_all("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].up_dn, vecs[i].sat_mode, vecs[i].load,
           int'(vecs[i].load_val), vecs[i].clr_ovf);
      chk_all(vecs[i].name, vecs[i].exp_count, vecs[i].exp_tc, vecs[i].exp_ovf);
    end

    // Asynchronous reset mid-cycle at count=5 with ovf set, pending step dropped.
    drive(1, 1, 0, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_all("rst_mid_count", 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held_edge", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 1, 0, 0, 0, 0);
    chk_all("first_step_after_rst", 1, 0, 0);

    // Reset while tc is high must drop tc without a clock edge.
    step(0, 1, 0, 1, 9, 0);
    step(1, 1, 0, 0, 0, 0);
    chk_all("tc_before_rst", 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("rst_drops_tc", 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 1, 0, 0, 0);
    chk_all("sat_dn_from_rst", 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
